alu_rmw_sequencer: RTL and testbench

- Multi-cycle controller that runs 6502 read-modify-write memory instructions (INC, DEC, ASL, LSR, ROL, ROR on memory) through the shared 8-bit ALU.
- Sequence per instruction: read operand, dummy-write the original value (6502-accurate), one ALU execute cycle, write the result, then one-cycle done pulse with flag update.
- Sits between the instruction decoder (start/op/address) and the CPU memory bus, and owns the ALU operand/operation select while busy.

---
 rtl/alu_rmw_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_rmw_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rmw_sequencer.sv
// Sequencer for 6502 read-modify-write memory instructions: read, dummy write,
// one ALU cycle, result write, then a done pulse that carries the N/Z/C update.
//
// state  | meaning
// IDLE   | waiting for start; an illegal op pulses err
// READ   | bus read of the operand at the latched address
// DWRITE | dummy write of the unmodified operand
// EXEC   | single ALU cycle; result and flags registered
// WRITE  | bus write of the result
// DONE   | done/flag_we pulse, then back to IDLE
module alu_rmw_sequencer #(
    parameter int         ADDR_WIDTH  = 16,
    parameter logic [3:0] ALU_OP_PASS = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2:0]            rmw_op,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  carry_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    input  logic                  mem_ready,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic [3:0]            alu_op,
    output logic                  alu_carry_in,
    input  logic [8:0]            alu_f,
    input  logic                  alu_carry,
    input  logic                  alu_negative,
    input  logic                  alu_zero,
    output logic                  flag_we,
    output logic                  flag_n,
    output logic                  flag_z,
    output logic                  flag_c
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_DWRITE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [2:0] OP_INC = 3'd0;
    localparam logic [2:0] OP_DEC = 3'd1;
    localparam logic [2:0] OP_ASL = 3'd2;
    localparam logic [2:0] OP_LSR = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ROR = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            op_q, op_d;
    logic                  carry_q, carry_d;
    logic [7:0]            operand_q, operand_d;
    logic [7:0]            result_q, result_d;
    logic [7:0]            alu_ab_q, alu_ab_d;
    logic                  fn_q, fn_d;
    logic                  fz_q, fz_d;
    logic                  fc_q, fc_d;
    logic                  err_q, err_d;
    logic [3:0]            exec_op;
    logic                  alu_f_unused;

    // Carry out of the ALU arrives on alu_carry; the ninth result bit is redundant.
    assign alu_f_unused = alu_f[8];

    always_comb begin
        exec_op = ALU_OP_PASS;
        case (op_q)
            OP_INC:  exec_op = 4'd5;
            OP_DEC:  exec_op = 4'd6;
            OP_ASL:  exec_op = 4'd9;
            OP_LSR:  exec_op = 4'd10;
            OP_ROL:  exec_op = 4'd8;
            OP_ROR:  exec_op = 4'd7;
            default: exec_op = ALU_OP_PASS;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        op_d      = op_q;
        carry_d   = carry_q;
        operand_d = operand_q;
        result_d  = result_q;
        alu_ab_d  = alu_ab_q;
        fn_d      = fn_q;
        fz_d      = fz_q;
        fc_d      = fc_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (rmw_op <= OP_ROR) begin
                        addr_d  = addr;
                        op_d    = rmw_op;
                        carry_d = carry_in;
                        state_d = S_READ;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (mem_ready) begin
                    operand_d = mem_rdata;
                    state_d   = S_DWRITE;
                end
            end
            S_DWRITE: begin
                if (mem_ready) begin
                    alu_ab_d = operand_q;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_f[7:0];
                fn_d     = alu_negative;
                fz_d     = alu_zero;
                // INC/DEC do not touch C on a 6502.
                fc_d     = (op_q == OP_INC || op_q == OP_DEC) ? carry_q : alu_carry;
                state_d  = S_WRITE;
            end
            S_WRITE: begin
                if (mem_ready) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            operand_q <= '0;
            result_q  <= '0;
            alu_ab_q  <= '0;
            fn_q      <= 1'b0;
            fz_q      <= 1'b0;
            fc_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            op_q      <= op_d;
            carry_q   <= carry_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            alu_ab_q  <= alu_ab_d;
            fn_q      <= fn_d;
            fz_q      <= fz_d;
            fc_q      <= fc_d;
            err_q     <= err_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign flag_we      = (state_q == S_DONE);
    assign err          = err_q;
    assign mem_req      = (state_q == S_READ) || (state_q == S_DWRITE) || (state_q == S_WRITE);
    assign mem_we       = (state_q == S_DWRITE) || (state_q == S_WRITE);
    assign mem_addr     = addr_q;
    assign mem_wdata    = (state_q == S_WRITE) ? result_q : operand_q;
    assign alu_a        = alu_ab_q;
    assign alu_b        = alu_ab_q;
    assign alu_op       = (state_q == S_EXEC) ? exec_op : ALU_OP_PASS;
    assign alu_carry_in = (state_q == S_EXEC) && carry_q;
    assign flag_n       = fn_q;
    assign flag_z       = fz_q;
    assign flag_c       = fc_q;

endmodule

// File: tb/tb_alu_rmw_sequencer.sv
// Randomized bench for alu_rmw_sequencer with a byte-array memory, a 6502-style
// ALU stand-in and an arithmetic reference for every read-modify-write op.
module tb_alu_rmw_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  rmw_op;
    logic [15:0] addr;
    logic        carry_in;
    logic        busy, done, err;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        alu_carry_in;
    logic [8:0]  alu_f;
    logic        alu_carry, alu_negative, alu_zero;
    logic        flag_we, flag_n, flag_z, flag_c;

    logic [7:0]  mem [0:65535];
    int          n_chk  = 0;
    int          n_pass = 0;

    alu_rmw_sequencer #(.ADDR_WIDTH(16), .ALU_OP_PASS(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rmw_op(rmw_op), .addr(addr),
        .carry_in(carry_in), .busy(busy), .done(done), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry_in(alu_carry_in),
        .alu_f(alu_f), .alu_carry(alu_carry), .alu_negative(alu_negative),
        .alu_zero(alu_zero), .flag_we(flag_we), .flag_n(flag_n), .flag_z(flag_z),
        .flag_c(flag_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    // Stand-in for the shared ALU. INC/DEC report a carry unrelated to the
    // real one so a sequencer that takes it instead of the latched C is visible.
    logic [7:0] alu_res;
    logic       alu_c;
    always_comb begin
        alu_res = alu_a;
        alu_c   = 1'b0;
        case (alu_op)
            4'd5:  begin alu_res = alu_a + 8'd1; alu_c = ~alu_carry_in; end
            4'd6:  begin alu_res = alu_a - 8'd1; alu_c = ~alu_carry_in; end
            4'd9:  begin alu_res = {alu_a[6:0], 1'b0};         alu_c = alu_a[7]; end
            4'd10: begin alu_res = {1'b0, alu_a[7:1]};         alu_c = alu_a[0]; end
            4'd8:  begin alu_res = {alu_a[6:0], alu_carry_in}; alu_c = alu_a[7]; end
            4'd7:  begin alu_res = {alu_carry_in, alu_a[7:1]}; alu_c = alu_a[0]; end
            default: begin alu_res = alu_a; alu_c = 1'b0; end
        endcase
    end
    assign alu_f        = {alu_c, alu_res};
    assign alu_carry    = alu_c;
    assign alu_negative = alu_res[7];
    assign alu_zero     = (alu_res == 8'd0);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    task automatic ref_rmw(input int op, input int v, input int cin,
                           output int res, output int c, output int code);
        res = v; c = cin; code = 15;
        case (op)
            0: begin res = (v + 1) % 256;         c = cin;     code = 5;  end
            1: begin res = (v + 255) % 256;       c = cin;     code = 6;  end
            2: begin res = (v * 2) % 256;         c = v / 128; code = 9;  end
            3: begin res = v / 2;                 c = v % 2;   code = 10; end
            4: begin res = (v * 2 + cin) % 256;   c = v / 128; code = 8;  end
            5: begin res = v / 2 + cin * 128;     c = v % 2;   code = 7;  end
            default: ;
        endcase
    endtask

    // Runs one instruction from a negedge with the DUT idle; phase index p
    // walks the expected bus sequence read, dummy write, exec, write, done.
    task automatic run_op(input int op, input logic [15:0] a, input logic [7:0] v,
                          input logic cin, input int rd_st, input int wr_st, input bit rnd);
        int res, c, code, p, stalls, xfers, cyc;
        bit rdy, fin;
        ref_rmw(op, int'(v), int'(cin), res, c, code);
        mem[a]   = v;
        start    = 1'b1;
        rmw_op   = 3'(op);
        addr     = a;
        carry_in = cin;
        p = 0; stalls = 0; xfers = 0; fin = 0;
        for (cyc = 1; cyc <= 200 && !fin; cyc++) begin
            @(negedge clk);
            start     = 1'($urandom);
            addr      = 16'($urandom);
            rmw_op    = 3'($urandom);
            carry_in  = 1'($urandom);
            mem_rdata = mem[mem_addr];
            chk("busy", busy, 1);
            chk("mem_addr", mem_addr, a);
            case (p)
                0: begin
                    chk("rd_req", {mem_req, mem_we}, 2'b10);
                    chk("rd_aluop", alu_op, 4'hF);
                end
                1: begin
                    chk("dw_req", {mem_req, mem_we}, 2'b11);
                    chk("dw_data", mem_wdata, v);
                end
                2: begin
                    chk("ex_req", mem_req, 0);
                    chk("ex_aluop", alu_op, code);
                    chk("ex_a", alu_a, v);
                    chk("ex_b", alu_b, v);
                    chk("ex_cin", alu_carry_in, cin);
                end
                3: begin
                    chk("wr_req", {mem_req, mem_we}, 2'b11);
                    chk("wr_data", mem_wdata, res);
                    chk("wr_aluop", alu_op, 4'hF);
                    chk("wr_done", {done, flag_we}, 2'b00);
                end
                default: begin
                    chk("dn_pulse", {done, flag_we, mem_req}, 3'b110);
                    chk("dn_flags", {flag_n, flag_z, flag_c},
                        {res >= 128, res == 0, c[0]});
                    chk("dn_cycle", cyc, 5 + stalls);
                    chk("dn_hold_a", alu_a, v);
                end
            endcase
            if (p == 0 || p == 1 || p == 3) begin
                if (p == 0 && rd_st > 0) begin
                    rdy = 0; rd_st--;
                end else if (p == 3 && wr_st > 0) begin
                    rdy = 0; wr_st--;
                end else begin
                    rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                mem_ready = rdy;
                if (!rdy) begin
                    stalls++;
                end else begin
                    xfers++;
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    p = (p == 0) ? 1 : (p == 1) ? 2 : 4;
                end
            end else if (p == 2) begin
                mem_ready = 1'($urandom);
                p = 3;
            end else begin
                start = 1'b1;
                fin   = 1;
            end
        end
        chk("completed", fin, 1);
        chk("mem_final", mem[a], res);
        chk("xfers", xfers, 3);
        @(negedge clk);
        start     = 1'b0;
        mem_ready = 1'b1;
        chk("idle_after", {busy, done, flag_we, mem_req}, 4'b0000);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        rmw_op    = 3'd0;
        addr      = 16'd0;
        carry_in  = 1'b0;
        mem_rdata = 8'd0;
        mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, done, err, mem_req, mem_we, flag_we}, 6'd0);
        chk("rst_bus", {mem_addr, mem_wdata}, 24'd0);
        chk("rst_alu", {alu_a, alu_b, alu_op, alu_carry_in}, {16'd0, 4'hF, 1'b0});
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 16'h0010, 8'hFF, 1'b1, 0, 0, 0);
        run_op(2, 16'h0200, 8'h81, 1'b0, 0, 0, 0);
        run_op(5, 16'h0301, 8'h01, 1'b1, 0, 0, 0);
        run_op(1, 16'h0302, 8'h00, 1'b0, 0, 0, 0);
        run_op(1, 16'h0303, 8'h00, 1'b1, 0, 0, 0);
        run_op(3, 16'hFFFF, 8'h01, 1'b0, 0, 0, 0);
        run_op(4, 16'h8000, 8'h80, 1'b1, 0, 0, 0);
        run_op(4, 16'h1234, 8'hC3, 1'b1, 3, 2, 0);

        for (int op = 6; op <= 7; op++) begin
            start  = 1'b1;
            rmw_op = 3'(op);
            addr   = 16'h0444;
            @(negedge clk);
            start = 1'b0;
            chk("err_pulse", {err, busy, mem_req}, 3'b100);
            @(negedge clk);
            chk("err_clear", {err, busy, mem_req}, 3'b000);
        end

        mem[16'h0500] = 8'h42;
        start     = 1'b1;
        rmw_op    = 3'd0;
        addr      = 16'h0500;
        carry_in  = 1'b0;
        mem_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            start     = 1'b0;
            mem_rdata = mem[mem_addr];
        end
        @(negedge clk);
        chk("pre_rst_wr", {mem_req, mem_we, mem_wdata}, {2'b11, 8'h43});
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drop", {mem_req, mem_we, busy}, 3'b000);
        mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_nodone", {done, flag_we, mem_req}, 3'b000);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 16'h0500, 8'h42, 1'b1, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            run_op($urandom_range(0, 5), 16'($urandom), 8'($urandom), 1'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
